// File: rtl/axis_switch_arb.sv
// N-to-1 AXI-Stream switch: packet-atomic grant (fixed priority or round-robin) feeding a 2-entry skid buffer.
// Latency: request seen in IDLE -> grant at next edge -> first beat accepted that cycle -> m_axis_tvalid one cycle later.
// Backpressure: only the granted input sees tready, taken from registered buffer occupancy, never from m_axis_tready.

module axis_switch_arb #(
   parameter int  DATAW    = 24,
   parameter int  NUM_SI   = 3,
   parameter int  ARB_MODE = 0,
   localparam int GW       = (NUM_SI > 1) ? $clog2(NUM_SI) : 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_SI-1:0]           s_en,
   input  logic [NUM_SI*DATAW-1:0]     s_axis_tdata,
   input  logic [NUM_SI-1:0]           s_axis_tvalid,
   output logic [NUM_SI-1:0]           s_axis_tready,
   input  logic [NUM_SI-1:0]           s_axis_tuser,
   input  logic [NUM_SI-1:0]           s_axis_tlast,
   input  logic [NUM_SI*DATAW/8-1:0]   s_axis_tkeep,
   output logic [DATAW-1:0]            m_axis_tdata,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tuser,
   output logic                        m_axis_tlast,
   output logic [DATAW/8-1:0]          m_axis_tkeep,
   output logic [GW-1:0]               grant_idx,
   output logic                        busy
);

   localparam int KW = DATAW / 8;

   typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

   typedef struct packed {
      logic [DATAW-1:0] data;
      logic [KW-1:0]    keep;
      logic             user;
      logic             last;
   } beat_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     grant_q, grant_d;
   logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
   logic              busy_q, busy_d;
   logic [1:0]        cnt_q, cnt_d;
   beat_t             head_q, head_d;
   beat_t             tail_q, tail_d;

   logic [NUM_SI-1:0] req;
   logic [NUM_SI-1:0] hi_req;
   logic [GW-1:0]     win_idx;
   beat_t             sel_beat;
   logic              sel_vld;
   logic              full;
   logic              accept;
   logic              pop;

   // Winner search: in round-robin, requests at or above the pointer take precedence; otherwise lowest index wins.
   always_comb begin
      req     = s_en & s_axis_tvalid;
      hi_req  = '0;
      win_idx = '0;
      for (int j = 0; j < NUM_SI; j++) begin
         if (ARB_MODE == 1 && GW'(j) >= rr_ptr_q) begin
            hi_req[j] = req[j];
         end
      end
      for (int j = NUM_SI - 1; j >= 0; j--) begin
         if (req[j]) begin
            win_idx = GW'(j);
         end
      end
      for (int j = NUM_SI - 1; j >= 0; j--) begin
         if (hi_req[j]) begin
            win_idx = GW'(j);
         end
      end
   end

   // Route the granted input's beat and valid toward the skid buffer.
   always_comb begin
      sel_vld  = 1'b0;
      sel_beat = '0;
      for (int j = 0; j < NUM_SI; j++) begin
         if (GW'(j) == grant_q) begin
            sel_vld       = s_axis_tvalid[j];
            sel_beat.data = s_axis_tdata[j*DATAW +: DATAW];
            sel_beat.keep = s_axis_tkeep[j*KW +: KW];
            sel_beat.user = s_axis_tuser[j];
            sel_beat.last = s_axis_tlast[j];
         end
      end
   end

   assign full   = (cnt_q == 2'd2);
   assign accept = (state_q == LOCK) && sel_vld && !full;
   assign pop    = (cnt_q != 2'd0) && m_axis_tready;

   // Only the locked input sees ready, and only while the buffer has room.
   always_comb begin
      s_axis_tready = '0;
      for (int j = 0; j < NUM_SI; j++) begin
         if (state_q == LOCK && GW'(j) == grant_q && !full) begin
            s_axis_tready[j] = 1'b1;
         end
      end
   end

   // Grant FSM: enable is only looked at in IDLE, so a packet always runs to its tlast.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      busy_d   = busy_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d  = LOCK;
               grant_d  = win_idx;
               busy_d   = 1'b1;
               rr_ptr_d = (win_idx == GW'(NUM_SI - 1)) ? '0 : win_idx + GW'(1);
            end
         end
         LOCK: begin
            if (accept && sel_beat.last) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Skid buffer: head drives the master port directly, tail catches the beat accepted while the head is stalled.
   always_comb begin
      head_d = head_q;
      tail_d = tail_q;
      cnt_d  = cnt_q;
      case (cnt_q)
         2'd0: begin
            if (accept) begin
               head_d = sel_beat;
               cnt_d  = 2'd1;
            end
         end
         2'd1: begin
            if (pop && accept) begin
               head_d = sel_beat;
            end else if (pop) begin
               cnt_d = 2'd0;
            end else if (accept) begin
               tail_d = sel_beat;
               cnt_d  = 2'd2;
            end
         end
         2'd2: begin
            if (pop) begin
               head_d = tail_q;
               cnt_d  = 2'd1;
            end
         end
         default: begin
            cnt_d = 2'd0;
         end
      endcase
   end

   // State and datapath registers; reset drops any partial packet and buffered beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         rr_ptr_q <= '0;
         busy_q   <= 1'b0;
         cnt_q    <= 2'd0;
         head_q   <= '0;
         tail_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         rr_ptr_q <= rr_ptr_d;
         busy_q   <= busy_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
         tail_q   <= tail_d;
      end
   end

   assign m_axis_tvalid = (cnt_q != 2'd0);
   assign m_axis_tdata  = head_q.data;
   assign m_axis_tkeep  = head_q.keep;
   assign m_axis_tuser  = head_q.user;
   assign m_axis_tlast  = head_q.last;
   assign grant_idx     = grant_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_axis_switch_arb.sv
// Bench for axis_switch_arb: fixed-priority instance (a) and round-robin instance (b) on shared slave buses.
// Latency: directed per-cycle vectors plus stream sequences with bounded loops.
// Backpressure: random m_axis_tready over a 64-beat stream with occupancy and stall-stability checks.

module tb_axis_switch_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  en_a, en_b;
   logic [71:0] tdata;
   logic [2:0]  tvalid, tuser, tlast;
   logic [8:0]  tkeep;
   logic        m_rdy;

   logic [2:0]  srdy_a, srdy_b;
   logic [23:0] mdat_a, mdat_b;
   logic        mvld_a, mvld_b, muser_a, muser_b, mlast_a, mlast_b, busy_a, busy_b;
   logic [2:0]  mkeep_a, mkeep_b;
   logic [1:0]  gnt_a, gnt_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axis_switch_arb #(.DATAW(24), .NUM_SI(3), .ARB_MODE(0)) dut_a (
      .clk(clk), .rst(rst), .s_en(en_a),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(srdy_a),
      .s_axis_tuser(tuser), .s_axis_tlast(tlast), .s_axis_tkeep(tkeep),
      .m_axis_tdata(mdat_a), .m_axis_tvalid(mvld_a), .m_axis_tready(m_rdy),
      .m_axis_tuser(muser_a), .m_axis_tlast(mlast_a), .m_axis_tkeep(mkeep_a),
      .grant_idx(gnt_a), .busy(busy_a)
   );

   axis_switch_arb #(.DATAW(24), .NUM_SI(3), .ARB_MODE(1)) dut_b (
      .clk(clk), .rst(rst), .s_en(en_b),
      .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(srdy_b),
      .s_axis_tuser(tuser), .s_axis_tlast(tlast), .s_axis_tkeep(tkeep),
      .m_axis_tdata(mdat_b), .m_axis_tvalid(mvld_b), .m_axis_tready(m_rdy),
      .m_axis_tuser(muser_b), .m_axis_tlast(mlast_b), .m_axis_tkeep(mkeep_b),
      .grant_idx(gnt_b), .busy(busy_b)
   );

   typedef struct packed {
      logic [2:0] en, vld, last;
      logic [7:0] d0, d1, d2;
      logic [2:0] srdy;
      logic       mvld;
      logic [7:0] mdat;
      logic       mlast;
      logic [1:0] gnt;
      logic       busy;
   } vec_t;

   vec_t vt [0:23];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [2:0] en, input logic [2:0] vld, input logic [2:0] last,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
      en_a   = en;
      tvalid = vld;
      tlast  = last;
      tdata  = {16'h0, d2, 16'h0, d1, 16'h0, d0};
      tuser  = {d2[0], d1[0], d0[0]};
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int          rr_seq [3];
      logic [7:0]  dd [3];
      logic [2:0]  lst;
      int          order [$];
      int          acc_cyc [$];
      logic [31:0] rr_out [$];
      logic [31:0] got [$];
      int          sent, rcv, occ, s;
      logic        acc, pop, prev_stall;
      logic [31:0] prev_pl;

      // single packet on s1 (0x10..0x13)
      vt[0]  = '{3'b010, 3'b010, 3'b000, 8'h00, 8'h10, 8'h00, 3'b000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      vt[1]  = '{3'b010, 3'b010, 3'b000, 8'h00, 8'h10, 8'h00, 3'b010, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1};
      vt[2]  = '{3'b010, 3'b010, 3'b000, 8'h00, 8'h11, 8'h00, 3'b010, 1'b1, 8'h10, 1'b0, 2'd1, 1'b1};
      vt[3]  = '{3'b010, 3'b010, 3'b000, 8'h00, 8'h12, 8'h00, 3'b010, 1'b1, 8'h11, 1'b0, 2'd1, 1'b1};
      vt[4]  = '{3'b010, 3'b010, 3'b010, 8'h00, 8'h13, 8'h00, 3'b010, 1'b1, 8'h12, 1'b0, 2'd1, 1'b1};
      vt[5]  = '{3'b010, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h13, 1'b1, 2'd1, 1'b0};
      vt[6]  = '{3'b010, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
      // fixed priority: s0 and s2 contend, s0 first
      vt[7]  = '{3'b101, 3'b101, 3'b000, 8'h20, 8'h00, 8'h40, 3'b000, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0};
      vt[8]  = '{3'b101, 3'b101, 3'b000, 8'h20, 8'h00, 8'h40, 3'b001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
      vt[9]  = '{3'b101, 3'b101, 3'b001, 8'h21, 8'h00, 8'h40, 3'b001, 1'b1, 8'h20, 1'b0, 2'd0, 1'b1};
      vt[10] = '{3'b101, 3'b100, 3'b000, 8'h00, 8'h00, 8'h40, 3'b000, 1'b1, 8'h21, 1'b1, 2'd0, 1'b0};
      vt[11] = '{3'b101, 3'b100, 3'b000, 8'h00, 8'h00, 8'h40, 3'b100, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1};
      vt[12] = '{3'b101, 3'b100, 3'b100, 8'h00, 8'h00, 8'h41, 3'b100, 1'b1, 8'h40, 1'b0, 2'd2, 1'b1};
      vt[13] = '{3'b101, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b1, 8'h41, 1'b1, 2'd2, 1'b0};
      vt[14] = '{3'b101, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0};
      // enable drop after beat 2 of a 5-beat packet on s0
      vt[15] = '{3'b001, 3'b001, 3'b000, 8'h50, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0};
      vt[16] = '{3'b001, 3'b001, 3'b000, 8'h50, 8'h00, 8'h00, 3'b001, 1'b0, 8'h00, 1'b0, 2'd0, 1'b1};
      vt[17] = '{3'b001, 3'b001, 3'b000, 8'h51, 8'h00, 8'h00, 3'b001, 1'b1, 8'h50, 1'b0, 2'd0, 1'b1};
      vt[18] = '{3'b000, 3'b001, 3'b000, 8'h52, 8'h00, 8'h00, 3'b001, 1'b1, 8'h51, 1'b0, 2'd0, 1'b1};
      vt[19] = '{3'b000, 3'b001, 3'b000, 8'h53, 8'h00, 8'h00, 3'b001, 1'b1, 8'h52, 1'b0, 2'd0, 1'b1};
      vt[20] = '{3'b000, 3'b001, 3'b001, 8'h54, 8'h00, 8'h00, 3'b001, 1'b1, 8'h53, 1'b0, 2'd0, 1'b1};
      vt[21] = '{3'b000, 3'b001, 3'b000, 8'h60, 8'h00, 8'h00, 3'b000, 1'b1, 8'h54, 1'b1, 2'd0, 1'b0};
      vt[22] = '{3'b000, 3'b001, 3'b000, 8'h60, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};
      vt[23] = '{3'b000, 3'b001, 3'b000, 8'h60, 8'h00, 8'h00, 3'b000, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};

      rst   = 1'b1;
      en_b  = 3'b000;
      m_rdy = 1'b1;
      tkeep = {3'b101, 3'b110, 3'b111};
      drive(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
      repeat (3) @(negedge clk);
      #1;
      chk("rst_mvld",  32'(mvld_a),  32'(0));
      chk("rst_mdat",  32'(mdat_a),  32'(0));
      chk("rst_mlast", 32'(mlast_a), 32'(0));
      chk("rst_muser", 32'(muser_a), 32'(0));
      chk("rst_mkeep", 32'(mkeep_a), 32'(0));
      chk("rst_srdy",  32'(srdy_a),  32'(0));
      chk("rst_gnt",   32'(gnt_a),   32'(0));
      chk("rst_busy",  32'(busy_a),  32'(0));
      chk("rst_b_mvld", 32'(mvld_b), 32'(0));
      chk("rst_b_busy", 32'(busy_b), 32'(0));
      chk("rst_b_gnt",  32'(gnt_b),  32'(0));
      chk("rst_b_srdy", 32'(srdy_b), 32'(0));
      rst = 1'b0;

      for (int k = 0; k < 24; k++) begin
         @(negedge clk);
         drive(vt[k].en, vt[k].vld, vt[k].last, vt[k].d0, vt[k].d1, vt[k].d2);
         #1;
         chk($sformatf("v%0d_srdy", k), 32'(srdy_a), 32'(vt[k].srdy));
         chk($sformatf("v%0d_mvld", k), 32'(mvld_a), 32'(vt[k].mvld));
         chk($sformatf("v%0d_gnt", k),  32'(gnt_a),  32'(vt[k].gnt));
         chk($sformatf("v%0d_busy", k), 32'(busy_a), 32'(vt[k].busy));
         if (vt[k].mvld) begin
            chk($sformatf("v%0d_mdat", k),  32'(mdat_a),  32'(vt[k].mdat));
            chk($sformatf("v%0d_mlast", k), 32'(mlast_a), 32'(vt[k].mlast));
            chk($sformatf("v%0d_muser", k), 32'(muser_a), 32'(vt[k].mdat[0]));
            chk($sformatf("v%0d_mkeep", k), 32'(mkeep_a), 32'(3'b111 ^ {1'b0, vt[k].gnt}));
         end
      end
      @(negedge clk);
      drive(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);

      // round-robin: all three inputs send back-to-back 2-beat packets into instance b
      en_b = 3'b111;
      for (int i = 0; i < 3; i++) rr_seq[i] = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            dd[i]  = 8'((i << 4) | (rr_seq[i] & 15));
            lst[i] = rr_seq[i][0];
         end
         drive(3'b000, 3'b111, lst, dd[0], dd[1], dd[2]);
         #1;
         if (mvld_b && m_rdy) rr_out.push_back(32'({mkeep_b, muser_b, mlast_b, mdat_b}));
         for (int i = 0; i < 3; i++) begin
            if (srdy_b[i]) begin
               if (order.size() < 12) begin
                  order.push_back(i);
                  acc_cyc.push_back(c);
               end
               rr_seq[i]++;
            end
         end
      end
      @(negedge clk);
      en_b = 3'b000;
      drive(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
      chk("rr_count", 32'(order.size()), 32'(12));
      chk("rr_out_count", 32'(rr_out.size() >= 12), 32'(1));
      for (int k = 0; k < order.size(); k++) begin
         chk($sformatf("rr_order%0d", k), 32'(order[k]), 32'((k / 2) % 3));
         if (k > 0) chk($sformatf("rr_gap%0d", k), 32'(acc_cyc[k] - acc_cyc[k-1]), 32'((k % 2 == 0) ? 2 : 1));
      end
      for (int k = 0; k < rr_out.size() && k < 12; k++) begin
         int ei, es;
         ei = (k / 2) % 3;
         es = (k / 6) * 2 + (k % 2);
         chk($sformatf("rr_out%0d", k), rr_out[k],
             32'({3'(3'b111 ^ 3'(ei)), 1'(es & 1), 1'(k % 2), 24'((ei << 4) | es)}));
      end

      // back-pressure: 64 beats on s1 (tlast every 8th) with random m_axis_tready
      sent = 0; rcv = 0; occ = 0; prev_stall = 1'b0; prev_pl = '0;
      for (int c = 0; c < 1500 && rcv < 64; c++) begin
         @(negedge clk);
         m_rdy = 1'($urandom_range(0, 1));
         drive(3'b010, {1'b0, sent < 64, 1'b0}, {1'b0, (sent % 8) == 7, 1'b0}, 8'h00, 8'(sent), 8'h00);
         #1;
         if (prev_stall) chk("bp_stable", 32'({mvld_a, mlast_a, mdat_a}), prev_pl);
         if (occ == 2) chk("bp_full_rdy", 32'(srdy_a), 32'(0));
         acc = srdy_a[1] && tvalid[1];
         pop = mvld_a && m_rdy;
         if (pop) begin
            chk("bp_data", 32'(mdat_a), 32'(rcv));
            chk("bp_last", 32'(mlast_a), 32'((rcv % 8) == 7));
            rcv++;
         end
         occ = occ + int'(acc) - int'(pop);
         sent = sent + int'(acc);
         prev_stall = mvld_a && !m_rdy;
         prev_pl = 32'({1'b1, mlast_a, mdat_a});
      end
      chk("bp_count", 32'(rcv), 32'(64));

      // reset during beat 3 of an 8-beat packet on s1
      @(negedge clk);
      m_rdy = 1'b1;
      drive(3'b010, 3'b010, 3'b000, 8'h00, 8'h70, 8'h00);
      @(negedge clk);
      drive(3'b010, 3'b010, 3'b000, 8'h00, 8'h70, 8'h00);
      @(negedge clk);
      drive(3'b010, 3'b010, 3'b000, 8'h00, 8'h71, 8'h00);
      @(negedge clk);
      drive(3'b010, 3'b010, 3'b000, 8'h00, 8'h72, 8'h00);
      rst = 1'b1;
      #1;
      chk("mid_busy", 32'(busy_a), 32'(1));
      @(negedge clk);
      rst = 1'b0;
      drive(3'b000, 3'b000, 3'b000, 8'h00, 8'h00, 8'h00);
      #1;
      chk("mid_mvld",  32'(mvld_a),  32'(0));
      chk("mid_mdat",  32'(mdat_a),  32'(0));
      chk("mid_mlast", 32'(mlast_a), 32'(0));
      chk("mid_muser", 32'(muser_a), 32'(0));
      chk("mid_mkeep", 32'(mkeep_a), 32'(0));
      chk("mid_srdy",  32'(srdy_a),  32'(0));
      chk("mid_gnt",   32'(gnt_a),   32'(0));
      chk("mid_busyr", 32'(busy_a),  32'(0));
      s = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         drive(3'b100, {s < 2, 1'b0, 1'b0}, {s == 1, 1'b0, 1'b0}, 8'h00, 8'h00, 8'(8'h80 + s));
         #1;
         if (mvld_a && m_rdy) got.push_back(32'({mlast_a, mdat_a}));
         if (srdy_a[2] && tvalid[2]) s++;
      end
      chk("post_count", 32'(got.size()), 32'(2));
      if (got.size() > 0) chk("post_beat0", got[0], 32'({1'b0, 24'h80}));
      if (got.size() > 1) chk("post_beat1", got[1], 32'({1'b1, 24'h81}));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axis_switch_arb.md
# axis_switch_arb

Parametrised N-to-1 AXI-Stream switch with packet-atomic arbitration and a registered, full-throughput output stage. Selects among NUM_SI enabled slave streams by fixed priority or round-robin, holds each grant until the packet's tlast beat, and back-pressures every non-granted input. Sits in the video/DMA datapath ahead of a single AXIS consumer, where a stream must not be switched mid-packet.

## Interface
Parameters:
- DATAW, 24: tdata width in bits; multiple of 8.
- NUM_SI, 3: number of slave inputs, 1..16.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- GW, derived: max(1, $clog2(NUM_SI)); not user-set.

Ports (slave buses flat-packed, slice i at [i*W +: W]):
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- s_en  in  NUM_SI  per-input enable; disabled inputs are never granted.
- s_axis_tdata  in  NUM_SI*DATAW  slave data.
- s_axis_tvalid  in  NUM_SI  slave valid.
- s_axis_tready  out  NUM_SI  slave ready; at most one bit high.
- s_axis_tuser / s_axis_tlast  in  NUM_SI each  sideband / end of packet.
- s_axis_tkeep  in  NUM_SI*DATAW/8  byte keep.
- m_axis_tdata  out  DATAW  master data.
- m_axis_tvalid  out  1;  m_axis_tready  in  1.
- m_axis_tuser / m_axis_tlast  out  1 each.
- m_axis_tkeep  out  DATAW/8.
- grant_idx  out  GW  index of the current/last granted input.
- busy  out  1  high while a packet is locked.

## Operation
- FSM states: IDLE, LOCK.
- IDLE: request vector req = s_en & s_axis_tvalid. If req != 0, register the winner into grant_idx, set busy, go to LOCK. All s_axis_tready = 0 in IDLE.
- Fixed priority: lowest set index of req. Round-robin: first set index searching upward from grant_idx+1, wrapping modulo NUM_SI; after reset the search starts at index 0.
- LOCK: s_axis_tready[grant_idx] = skid-buffer not-full; all others 0. A beat is accepted when tvalid & tready on the granted input and is pushed into the output stage unchanged (tdata, tuser, tlast, tkeep).
- Accepted beat with tlast = 1: clear busy, return to IDLE on the next edge. Accepted beat with tlast = 0: remain in LOCK.
- s_en[grant_idx] falling during LOCK does not abort: the packet runs to tlast. The enable is sampled only in IDLE.
- Output stage: 2-entry skid buffer. m_axis_* is driven from registers only, with no combinational path from m_axis_tready to s_axis_tready. Sustains 1 beat/cycle while m_axis_tready = 1.
- NUM_SI = 1: the arbiter degenerates; grant_idx is constant 0.

## Timing
- Reset (rst = 1 at an edge): state IDLE, m_axis_tvalid = 0, m_axis_tdata/tuser/tlast/tkeep = 0, s_axis_tready = 0, grant_idx = 0, busy = 0, skid buffer emptied. Reset mid-packet discards the buffered beats and the partial packet.
- Request to first master beat: request seen in IDLE at cycle n, grant registered at edge n+1, first beat accepted in cycle n+1, m_axis_tvalid high in cycle n+2.
- Packet gap: exactly one IDLE cycle between the tlast acceptance and the next grant's first acceptance (at most 1 bubble per packet).
- Back-pressure: with m_axis_tready = 0, at most 2 beats are absorbed and s_axis_tready drops the cycle after the buffer holds 2 beats. No beat is lost or duplicated.
- m_axis_tvalid, once high, stays high with stable payload until m_axis_tready = 1.

## Test plan
- Single packet: only s1 enabled, a 4-beat packet with tdata 0x10..0x13 and tlast on beat 4, m_axis_tready = 1 -> 4 beats out in order starting at cycle n+2, grant_idx = 1, busy drops after beat 4.
- Fixed priority (ARB_MODE = 0): s0 and s2 both valid in IDLE -> s0 granted first; s2 is granted only after s0's tlast, and s_axis_tready[2] = 0 throughout s0's packet.
- Round-robin (ARB_MODE = 1): s0, s1 and s2 continuously sending 2-beat packets -> grant order 0, 1, 2, 0, 1, 2, with one bubble cycle between packets.
- Enable drop mid-packet: deassert s_en[0] after beat 2 of a 5-beat packet -> all 5 beats are delivered, and s0 is not granted again while disabled.
- Back-pressure: m_axis_tready toggled 0/1 randomly over a 64-beat stream -> output sequence identical to the input, no s_axis_tready while the buffer is full, and stable m_axis payload while stalled.
- Reset mid-packet: assert rst during beat 3 of 8 -> the next cycle shows all outputs at their reset values; after release, a new packet passes cleanly.
